// File: rtl/l2_cache_assoc.sv
// Write-back, write-allocate, N-way set-associative L2 cache with tree pseudo-LRU replacement.
// Optional performance counters are enabled by defining L2_PERF_CNT_EN.
module l2_cache_assoc #(
  parameter int NUM_SETS  = 8,
  parameter int NUM_WAYS  = 4,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [31:0]          mem_address,
  input  logic [LINE_BITS-1:0] mem_wdata,
  output logic [LINE_BITS-1:0] mem_rdata,
  output logic                 mem_resp,
  output logic [31:0]          pmem_address,
  output logic [LINE_BITS-1:0] pmem_wdata,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
`ifdef L2_PERF_CNT_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count,
  output logic [31:0]          wb_count
`endif
);

  localparam int OFF_BITS = $clog2(LINE_BITS / 8);
  localparam int IDX_BITS = $clog2(NUM_SETS);
  localparam int TAG_BITS = 32 - OFF_BITS - IDX_BITS;
  localparam int WAY_BITS = $clog2(NUM_WAYS);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WB, S_FILL, S_INSTALL} state_e;

  state_e                 state, state_n;
  logic [TAG_BITS-1:0]    req_tag;
  logic [IDX_BITS-1:0]    req_idx;
  logic [LINE_BITS-1:0]   req_wdata;
  logic                   req_write;
  logic                   recheck;
  logic [WAY_BITS-1:0]    victim_q, victim_c, hit_way;
  logic                   hit;

  logic [TAG_BITS-1:0]    tag_arr   [NUM_SETS][NUM_WAYS];
  logic [LINE_BITS-1:0]   data_arr  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]    valid_arr [NUM_SETS];
  logic [NUM_WAYS-1:0]    dirty_arr [NUM_SETS];
  logic [NUM_WAYS-2:0]    plru_arr  [NUM_SETS];

  logic unused_offset;
  assign unused_offset = ^mem_address[OFF_BITS-1:0];

  // Tree walk from the root: a node bit of 1 sends the victim search to the upper half.
  function automatic logic [WAY_BITS-1:0] plru_victim(input logic [NUM_WAYS-2:0] bits);
    logic [WAY_BITS-1:0] way;
    int node;
    way  = '0;
    node = 0;
    for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
      way[WAY_BITS-1-lvl] = bits[node];
      node = 2 * node + (bits[node] ? 2 : 1);
    end
    return way;
  endfunction

  function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] bits,
                                                      input logic [WAY_BITS-1:0] way);
    logic [NUM_WAYS-2:0] nb;
    int node;
    nb   = bits;
    node = 0;
    for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
      nb[node] = ~way[WAY_BITS-1-lvl];
      node = 2 * node + (way[WAY_BITS-1-lvl] ? 2 : 1);
    end
    return nb;
  endfunction

  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_arr[req_idx][w] && tag_arr[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
    victim_c = plru_victim(plru_arr[req_idx]);
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_arr[req_idx][w]) victim_c = WAY_BITS'(w);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // NOTE: every output and next-state variable gets a default first, so no path infers a latch.
  always_comb begin
    state_n      = state;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    case (state)
      S_IDLE:    if (mem_read || mem_write) state_n = S_CHECK;
      S_CHECK: begin
        if (hit) begin
          mem_resp  = 1'b1;
          mem_rdata = data_arr[req_idx][hit_way];
          state_n   = S_IDLE;
        end else if (valid_arr[req_idx][victim_c] && dirty_arr[req_idx][victim_c]) begin
          state_n = S_WB;
        end else begin
          state_n = req_write ? S_INSTALL : S_FILL;
        end
      end
      S_WB: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_arr[req_idx][victim_q], req_idx, {OFF_BITS{1'b0}}};
        if (pmem_resp) state_n = req_write ? S_INSTALL : S_FILL;
      end
      S_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, req_idx, {OFF_BITS{1'b0}}};
        if (pmem_resp) state_n = S_CHECK;
      end
      S_INSTALL: state_n = S_CHECK;
      default:   state_n = S_IDLE;
    endcase
  end

  assign pmem_wdata = data_arr[req_idx][victim_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_tag   <= '0;
      req_idx   <= '0;
      req_wdata <= '0;
      req_write <= 1'b0;
      recheck   <= 1'b0;
      victim_q  <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_arr[s] <= '0;
        dirty_arr[s] <= '0;
        plru_arr[s]  <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_read || mem_write) begin
            req_tag   <= mem_address[31 -: TAG_BITS];
            req_idx   <= mem_address[OFF_BITS +: IDX_BITS];
            req_wdata <= mem_wdata;
            req_write <= mem_write;
            recheck   <= 1'b0;
          end
        end
        S_CHECK: begin
          if (hit) begin
            plru_arr[req_idx] <= plru_touch(plru_arr[req_idx], hit_way);
            if (req_write) dirty_arr[req_idx][hit_way] <= 1'b1;
          end else begin
            victim_q <= victim_c;
          end
        end
        S_WB: if (pmem_resp) dirty_arr[req_idx][victim_q] <= 1'b0;
        S_FILL: begin
          if (pmem_resp) begin
            valid_arr[req_idx][victim_q] <= 1'b1;
            dirty_arr[req_idx][victim_q] <= 1'b0;
            recheck                      <= 1'b1;
          end
        end
        S_INSTALL: begin
          valid_arr[req_idx][victim_q] <= 1'b1;
          dirty_arr[req_idx][victim_q] <= 1'b1;
          recheck                      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: tag and data arrays carry no reset; the cleared valid bits make their contents irrelevant.
  always_ff @(posedge clk) begin
    case (state)
      S_CHECK: if (hit && req_write) data_arr[req_idx][hit_way] <= req_wdata;
      S_FILL: begin
        if (pmem_resp) begin
          data_arr[req_idx][victim_q] <= pmem_rdata;
          tag_arr[req_idx][victim_q]  <= req_tag;
        end
      end
      S_INSTALL: begin
        data_arr[req_idx][victim_q] <= req_wdata;
        tag_arr[req_idx][victim_q]  <= req_tag;
      end
      default: ;
    endcase
  end

`ifdef L2_PERF_CNT_EN
  // Saturating counters; re-check hits after a miss are not counted as hits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (state == S_CHECK && hit && !recheck && hit_count != '1) hit_count <= hit_count + 32'd1;
      if (state == S_CHECK && !hit && miss_count != '1)           miss_count <= miss_count + 32'd1;
      if (state == S_WB && pmem_resp && wb_count != '1)           wb_count <= wb_count + 32'd1;
    end
  end
`endif

endmodule
